// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow errors and a choice of registered or fall-through read.
module sync_fifo_flags #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter bit          FWFT       = 1'b0,
    parameter int unsigned AF_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_af_range
        $error("sync_fifo_flags: AF_THRESH %0d outside 1..%0d", AF_THRESH, DEPTH);
    end
    if (AE_THRESH > DEPTH - 1) begin : g_ae_range
        $error("sync_fifo_flags: AE_THRESH %0d outside 0..%0d", AE_THRESH, DEPTH - 1);
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;

    // Flags decode from the registered count only
    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_W'(DEPTH));
    assign almost_empty = (count_q <= CNT_W'(AE_THRESH));
    assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Accept decisions, pointer/count advance and sticky errors (set beats clear)
    always_comb begin
        wr_acc      = wr_en & ~full;
        rd_acc      = rd_en & ~empty;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = (overflow_q & ~err_clr) | (wr_en & full);
        underflow_d = (underflow_q & ~err_clr) | (rd_en & empty);
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    if (FWFT) begin : g_fwft
        assign rd_data  = mem_q[rd_ptr_q];
        assign rd_valid = ~empty;
    end else begin : g_reg_rd
        logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
        logic                  rd_valid_q, rd_valid_d;

        // Registered read: data lands one edge after an accepted read, then holds
        always_comb begin
            rd_valid_d = rd_acc;
            rd_data_d  = rd_data_q;
            if (rd_acc) begin
                rd_data_d = mem_q[rd_ptr_q];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags: registered-read instance checked through an
// expected-data queue, plus a fall-through instance checked directly.
module tb_sync_fifo_flags;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid, empty, full, almost_empty, almost_full, overflow, underflow;
    logic [AW:0]   count;

    logic [DW-1:0] f_wr_data = '0;
    logic          f_wr_en = 1'b0, f_rd_en = 1'b0, f_err_clr = 1'b0;
    logic [DW-1:0] f_rd_data;
    logic          f_rd_valid, f_empty, f_full, f_almost_empty, f_almost_full;
    logic          f_overflow, f_underflow;
    logic [AW:0]   f_count;

    sync_fifo_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b0)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .rd_en(rd_en),
        .err_clr(err_clr), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
        .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
        .count(count), .overflow(overflow), .underflow(underflow));

    sync_fifo_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b1)) dut_fwft (
        .clk(clk), .rst(rst), .wr_data(f_wr_data), .wr_en(f_wr_en), .rd_en(f_rd_en),
        .err_clr(f_err_clr), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .empty(f_empty),
        .full(f_full), .almost_empty(f_almost_empty), .almost_full(f_almost_full),
        .count(f_count), .overflow(f_overflow), .underflow(f_underflow));

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    logic rd_acc_now = 1'b0;
    logic rdv_exp    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected read-valid for the registered instance, one edge after an accepted read
    always @(posedge clk) rdv_exp <= rst ? 1'b0 : rd_acc_now;

    // Monitor: checks rd_valid every cycle and pops expected data whenever it is high
    always @(negedge clk) begin
        check("rd_valid", 32'(rd_valid), 32'(rdv_exp));
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_data_unexpected: got 0x%0h expected no output", rd_data);
            end else begin
                check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // One cycle of stimulus on the registered instance; the model decides acceptance
    task automatic step(input logic wr, input logic [DW-1:0] wd, input logic rd,
                        input logic clr = 1'b0, input logic rs = 1'b0);
        logic racc, wacc;
        rst     = rs;
        wr_en   = wr;
        wr_data = wd;
        rd_en   = rd;
        err_clr = clr;
        racc = rd && (model_q.size() != 0);
        wacc = wr && (model_q.size() != DEPTH);
        if (rs) begin
            model_q.delete();
            rd_acc_now = 1'b0;
        end else begin
            rd_acc_now = racc;
            if (racc) exp_q.push_back(model_q.pop_front());
            if (wacc) model_q.push_back(wd);
        end
        @(posedge clk);
        #1;
        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        rd_acc_now = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_ae", 32'(almost_empty), 1);
        check("rst_af", 32'(almost_full), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_unf", 32'(underflow), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_f_empty", 32'(f_empty), 1);
        check("rst_f_rd_valid", 32'(f_rd_valid), 0);

        // 1. Fill, then overflow and clear
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0);
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_af", 32'(almost_full), (i >= 13) ? 1 : 0);
            check("fill_full", 32'(full), (i == 15) ? 1 : 0);
        end
        check("fill_ovf_before", 32'(overflow), 0);
        step(1'b1, 8'hFF, 1'b0);
        check("ovf_set", 32'(overflow), 1);
        check("ovf_count", 32'(count), 16);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr", 32'(overflow), 0);

        // 2. Drain with registered read, then underflow
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check("drain_count", 32'(count), 32'(15 - i));
            check("drain_ae", 32'(almost_empty), (i >= 13) ? 1 : 0);
            check("drain_empty", 32'(empty), (i == 15) ? 1 : 0);
        end
        step(1'b0, 8'h00, 1'b1);
        check("unf_set", 32'(underflow), 1);
        step(1'b0, 8'h00, 1'b0);
        check("rd_data_hold", 32'(rd_data), 32'h0F);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("unf_clr", 32'(underflow), 0);

        // 3. Simultaneous access at full, then at empty
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        check("full_rw_count", 32'(count), 15);
        check("full_rw_ovf", 32'(overflow), 1);
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);
        check("empty_again", 32'(empty), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h77, 1'b1);
        check("empty_rw_count", 32'(count), 1);
        check("empty_rw_unf", 32'(underflow), 1);
        check("empty_rw_ovf", 32'(overflow), 0);

        // 4. Steady streaming at count 5 across pointer wrap
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        check("wrap_start_count", 32'(count), 5);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(8'h50 + i), 1'b1);
            check("wrap_count", 32'(count), 5);
        end

        // 6. Reset mid-operation at count 7 with a write pending
        step(1'b1, 8'hA0, 1'b0);
        step(1'b1, 8'hA1, 1'b0);
        check("pre_rst_count", 32'(count), 7);
        step(1'b1, 8'hA2, 1'b0, 1'b0, 1'b1);
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_unf", 32'(underflow), 0);
        check("mid_rst_ovf", 32'(overflow), 0);
        step(1'b1, 8'h99, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check("post_rst_data", 32'(rd_data), 32'h99);

        // 5. Fall-through instance
        f_wr_data = 8'hA5;
        f_wr_en   = 1'b1;
        @(posedge clk); #1;
        f_wr_en = 1'b0;
        check("fwft_data", 32'(f_rd_data), 32'hA5);
        check("fwft_valid", 32'(f_rd_valid), 1);
        check("fwft_count", 32'(f_count), 1);
        f_rd_en = 1'b1;
        @(posedge clk); #1;
        f_rd_en = 1'b0;
        check("fwft_pop_empty", 32'(f_empty), 1);
        check("fwft_pop_valid", 32'(f_rd_valid), 0);
        f_wr_en = 1'b1;
        f_wr_data = 8'hB1;
        @(posedge clk); #1;
        f_wr_data = 8'hB2;
        @(posedge clk); #1;
        f_wr_en = 1'b0;
        check("fwft_head1", 32'(f_rd_data), 32'hB1);
        f_rd_en = 1'b1;
        @(posedge clk); #1;
        f_rd_en = 1'b0;
        check("fwft_head2", 32'(f_rd_data), 32'hB2);
        check("fwft_count2", 32'(f_count), 1);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
